// File: rtl/rotorb_inverse.sv
// Builds the inverse of a 64-entry, 6-bit rotor table one entry per cycle,
// then serves backward lookups with a single cycle of latency.
module rotorb_inverse (
  input  logic         clk,
  input  logic         rst,
  input  logic         build_start,
  input  logic [383:0] rotorB_flat,
  output logic         build_busy,
  output logic         build_done,
  output logic         perm_error,
  input  logic         lookup_valid,
  input  logic [5:0]   lookup_in,
  output logic         lookup_ready,
  output logic         out_valid,
  output logic [5:0]   out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [5:0]  idx_reg;
  logic [5:0]  snap_reg [64];
  logic [5:0]  inv_reg  [64];
  logic [63:0] seen_reg;
  logic        perm_error_reg;
  logic        build_done_reg;
  logic        out_valid_reg;
  logic [5:0]  out_data_reg;

  logic        start_accept;
  logic        lookup_accept;
  logic        building;
  logic [5:0]  cur_val;
  logic        collision;
  logic        last_entry;

  assign building      = (state_reg == BUILD);
  assign start_accept  = build_start && !building;
  assign lookup_accept = lookup_valid && (state_reg == READY);
  assign cur_val       = snap_reg[idx_reg];
  assign collision     = seen_reg[cur_val];
  assign last_entry    = (idx_reg == 6'd63);

  // Next-state logic; the final entry's own collision must count towards the
  // READY/IDLE decision because perm_error_reg only reflects it a cycle later.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, READY: begin
        if (start_accept) begin
          state_next = BUILD;
        end
      end
      BUILD: begin
        if (last_entry) begin
          state_next = (perm_error_reg || collision) ? IDLE : READY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Per-entry snapshot, inverse table and seen bitmap.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          snap_reg[gi] <= 6'd0;
        end else if (start_accept) begin
          snap_reg[gi] <= rotorB_flat[6*gi +: 6];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          inv_reg[gi] <= 6'd0;
        end else if (building && (cur_val == 6'(gi))) begin
          inv_reg[gi] <= idx_reg;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          seen_reg[gi] <= 1'b0;
        end else if (start_accept) begin
          seen_reg[gi] <= 1'b0;
        end else if (building && (cur_val == 6'(gi))) begin
          seen_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Build sequencing: entry counter, sticky error flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= 6'd0;
      perm_error_reg <= 1'b0;
      build_done_reg <= 1'b0;
    end else begin
      build_done_reg <= 1'b0;
      if (start_accept) begin
        idx_reg        <= 6'd0;
        perm_error_reg <= 1'b0;
      end else if (building) begin
        idx_reg <= idx_reg + 6'd1;
        if (collision) begin
          perm_error_reg <= 1'b1;
        end
        if (last_entry) begin
          build_done_reg <= 1'b1;
        end
      end
    end
  end

  // Lookup path reads the table as it stands at acceptance, so a lookup
  // coinciding with build_start is served from the previous table.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= 6'd0;
    end else begin
      out_valid_reg <= lookup_accept;
      if (lookup_accept) begin
        out_data_reg <= inv_reg[lookup_in];
      end
    end
  end

  assign build_busy   = building;
  assign build_done   = build_done_reg;
  assign perm_error   = perm_error_reg;
  assign lookup_ready = (state_reg == READY);
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;

endmodule

// File: tb/tb_rotorb_inverse.sv
// Randomized bench for rotorb_inverse against a table-level reference model.
module tb_rotorb_inverse;

  logic         clk;
  logic         rst;
  logic         build_start;
  logic [383:0] rotorB_flat;
  logic         build_busy;
  logic         build_done;
  logic         perm_error;
  logic         lookup_valid;
  logic [5:0]   lookup_in;
  logic         lookup_ready;
  logic         out_valid;
  logic [5:0]   out_data;

  rotorb_inverse dut (
    .clk          (clk),
    .rst          (rst),
    .build_start  (build_start),
    .rotorB_flat  (rotorB_flat),
    .build_busy   (build_busy),
    .build_done   (build_done),
    .perm_error   (perm_error),
    .lookup_valid (lookup_valid),
    .lookup_in    (lookup_in),
    .lookup_ready (lookup_ready),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the inverse table as the spec defines it,
  // whether lookups are currently served, and the held output value.
  logic [5:0] tbl       [64];
  logic [5:0] model_inv [64];
  logic       model_ready;
  logic [5:0] last_out;
  logic [5:0] lk_list   [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},  build_busy,   0);
    check({tag, ".done"},  build_done,   0);
    check({tag, ".perr"},  perm_error,   0);
    check({tag, ".ready"}, lookup_ready, 0);
    check({tag, ".ovld"},  out_valid,    0);
    check({tag, ".odata"}, out_data,     0);
  endtask

  task automatic shuffle_table();
    logic [5:0] t;
    int j;
    for (int i = 0; i < 64; i++) tbl[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = tbl[i]; tbl[i] = tbl[j]; tbl[j] = t;
    end
  endtask

  // Move value v to position p by swapping, keeping tbl a permutation.
  task automatic place(input int p, input logic [5:0] v);
    logic [5:0] t;
    for (int j = 0; j < 64; j++) begin
      if (tbl[j] == v) begin
        t = tbl[p]; tbl[p] = tbl[j]; tbl[j] = t;
        break;
      end
    end
  endtask

  task automatic do_build(input string tag, input int abort_at, input bit restart10,
                          input bit with_lookup, input logic [5:0] lk);
    logic [383:0] flat;
    int           dup;
    logic         acc;
    logic [5:0]   exp_lk;
    logic         exp_perr;
    for (int i = 0; i < 64; i++) flat[6*i +: 6] = tbl[i];
    // First index whose value already appeared earlier in the table.
    dup = -1;
    for (int j = 0; j < 64 && dup < 0; j++)
      for (int i = 0; i < j; i++)
        if (tbl[i] == tbl[j]) dup = j;
    rotorB_flat = flat;
    build_start = 1'b1;
    acc = with_lookup && model_ready;
    exp_lk = model_inv[lk];
    if (with_lookup) begin
      lookup_valid = 1'b1;
      lookup_in    = lk;
    end
    tick();
    build_start  = 1'b0;
    lookup_valid = 1'b0;
    if (with_lookup) begin
      check({tag, ".lk_ovld"}, out_valid, 32'(acc));
      check({tag, ".lk_data"}, out_data, acc ? exp_lk : last_out);
      if (acc) last_out = exp_lk;
    end
    model_ready = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      exp_perr = (dup >= 0) && (k >= dup + 2);
      check({tag, ".busy"},  build_busy,   1);
      check({tag, ".done"},  build_done,   0);
      check({tag, ".ready"}, lookup_ready, 0);
      check({tag, ".perr"},  perm_error,   32'(exp_perr));
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero({tag, ".abort"});
        for (int i = 0; i < 64; i++) model_inv[i] = 6'd0;
        last_out = 6'd0;
        for (int c = 0; c < 70; c++) begin
          tick();
          check({tag, ".no_done"}, build_done, 0);
          check({tag, ".idle_busy"}, build_busy, 0);
        end
        return;
      end
      if (restart10 && k == 10) begin
        build_start = 1'b1;
        rotorB_flat = ~flat;
      end
      tick();
      build_start = 1'b0;
    end
    exp_perr = (dup >= 0);
    check({tag, ".end_busy"},  build_busy,   0);
    check({tag, ".end_done"},  build_done,   1);
    check({tag, ".end_perr"},  perm_error,   32'(exp_perr));
    check({tag, ".end_ready"}, lookup_ready, 32'(!exp_perr));
    for (int i = 0; i < 64; i++) model_inv[tbl[i]] = 6'(i);
    model_ready = !exp_perr;
    $display("build %s: dup_idx=%0d perm_error=%0d", tag, dup, perm_error);
  endtask

  task automatic run_lookups(input string tag, input int n, input bit rnd);
    logic       v;
    logic [5:0] a;
    logic       acc;
    logic [5:0] exp;
    for (int c = 0; c < n; c++) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a = rnd ? 6'($urandom_range(0, 63)) : lk_list[c];
      check({tag, ".ready"}, lookup_ready, 32'(model_ready));
      lookup_valid = v;
      lookup_in    = a;
      acc = v && model_ready;
      exp = model_inv[a];
      tick();
      check({tag, ".ovld"}, out_valid, 32'(acc));
      check({tag, ".odata"}, out_data, acc ? exp : last_out);
      check({tag, ".done"}, build_done, 0);
      if (acc) last_out = exp;
      if (acc)
        $display("lookup %s: in=%0d out=%0d exp=%0d", tag, a, out_data, exp);
    end
    lookup_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    build_start  = 1'b0;
    rotorB_flat  = '0;
    lookup_valid = 1'b0;
    lookup_in    = 6'd0;
    model_ready  = 1'b0;
    last_out     = 6'd0;
    for (int i = 0; i < 64; i++) model_inv[i] = 6'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Reversed table, lookup of 0 must give 63 one cycle after build_done.
    for (int i = 0; i < 64; i++) tbl[i] = 6'(63 - i);
    do_build("reverse", 0, 1'b0, 1'b0, 6'd0);
    lk_list[0] = 6'd0;
    run_lookups("reverse_lk0", 1, 1'b0);
    check("reverse_63", out_data, 63);
    run_lookups("reverse_rnd", 40, 1'b1);

    // Valid permutation with pinned entries, then the full consistency sweep.
    shuffle_table();
    place(0, 6'd57);
    place(25, 6'd0);
    place(62, 6'd1);
    do_build("pinned", 0, 1'b0, 1'b0, 6'd0);
    lk_list[0] = 6'd57; lk_list[1] = 6'd0; lk_list[2] = 6'd1;
    run_lookups("pinned_lk", 3, 1'b0);
    for (int i = 0; i < 64; i++) lk_list[i] = tbl[i];
    run_lookups("identity_sweep", 64, 1'b0);

    // Repeated build_start mid-build is ignored.
    shuffle_table();
    do_build("restart", 0, 1'b1, 1'b0, 6'd0);
    run_lookups("restart_rnd", 30, 1'b1);

    // Duplicate entry: error detected at idx 9, build ends in IDLE.
    shuffle_table();
    place(5, 6'd12);
    tbl[9] = 6'd12;
    do_build("dup", 0, 1'b0, 1'b0, 6'd0);
    run_lookups("dup_ignored", 20, 1'b1);
    for (int i = 0; i < 8; i++) lk_list[i] = 6'(i);
    run_lookups("dup_forced", 8, 1'b0);

    // Reset in the middle of a build, then a normal rebuild.
    shuffle_table();
    do_build("abort", 30, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 64; i++) tbl[i] = 6'(i);
    do_build("rebuild", 0, 1'b0, 1'b0, 6'd0);
    run_lookups("rebuild_rnd", 20, 1'b1);

    // build_start together with a lookup in READY.
    shuffle_table();
    do_build("overlap", 0, 1'b0, 1'b1, 6'd7);
    run_lookups("overlap_rnd", 40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
